// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/LSU requesters, the arbiter and the memory model.
// The arbiter takes the master view (it masters the memory bus); the surrounding core and memory take slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_valid;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rsp_data;

  logic                  ls_req_valid;
  logic                  ls_req_we;
  logic [DATA_W/8-1:0]   ls_req_be;
  logic [ADDR_W-1:0]     ls_req_addr;
  logic [DATA_W-1:0]     ls_req_wdata;
  logic                  ls_req_ready;
  logic                  ls_rsp_valid;
  logic [DATA_W-1:0]     ls_rsp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [DATA_W/8-1:0]   mem_req_be;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;

  modport master (
    input  if_req_valid, if_req_addr,
    input  ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output if_req_valid, if_req_addr,
    output ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU, one transaction
// in flight; LSU has priority, with a streak counter that eventually forces a fetch grant.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic               CLK,
  input  logic               RST,
  mem_port_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q;
  logic              owner_ls_q;
  logic [SW-1:0]     streak_q;
  logic [SW-1:0]     streak_d;

  logic              mem_req_valid_q;
  logic              mem_req_we_q;
  logic [BE_W-1:0]   mem_req_be_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [DATA_W-1:0] mem_req_wdata_q;

  logic              if_rsp_valid_q;
  logic              ls_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q;
  logic [DATA_W-1:0] ls_rsp_data_q;

  logic              contended;
  logic              if_win;
  logic              ls_win;
  logic              grant;

  // Ready is offered only in IDLE and never while reset is held, so reset drives every output low.
  always_comb begin
    contended = bus.if_req_valid & bus.ls_req_valid;
    if_win    = bus.if_req_valid & (~bus.ls_req_valid | (streak_q == STREAK_MAX));
    ls_win    = bus.ls_req_valid & ~if_win;
    grant     = (state_q == IDLE) & ~RST & (if_win | ls_win);
    streak_d  = '0;
    if (ls_win && contended) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
    end
  end

  assign bus.if_req_ready  = grant & if_win;
  assign bus.ls_req_ready  = grant & ls_win;
  assign bus.if_rsp_valid  = if_rsp_valid_q;
  assign bus.if_rsp_data   = if_rsp_data_q;
  assign bus.ls_rsp_valid  = ls_rsp_valid_q;
  assign bus.ls_rsp_data   = ls_rsp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_req_be    = mem_req_be_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      owner_ls_q      <= 1'b0;
      streak_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_be_q    <= '0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      if_rsp_valid_q  <= 1'b0;
      ls_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      ls_rsp_data_q   <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q         <= ISSUE;
            owner_ls_q      <= ls_win;
            streak_q        <= streak_d;
            mem_req_valid_q <= 1'b1;
            if (ls_win) begin
              mem_req_we_q    <= bus.ls_req_we;
              mem_req_be_q    <= bus.ls_req_be;
              mem_req_addr_q  <= bus.ls_req_addr;
              mem_req_wdata_q <= bus.ls_req_wdata;
            end else begin
              mem_req_we_q    <= 1'b0;
              mem_req_be_q    <= '1;
              mem_req_addr_q  <= bus.if_req_addr;
              mem_req_wdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          // Response goes only to the owner; back to IDLE in the same cycle the pulse is visible.
          if (bus.mem_rsp_valid) begin
            state_q <= IDLE;
            if (owner_ls_q) begin
              ls_rsp_valid_q <= 1'b1;
              ls_rsp_data_q  <= bus.mem_rsp_data;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= bus.mem_rsp_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected responses and memory requests are queued
// at stimulus time and popped by an independent negedge monitor.
module tb_mem_port_arbiter;

  typedef struct {bit ls; bit chk; logic [31:0] d;} rsp_t;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wd;} mreq_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if ia ();
  mem_port_arbiter_if ib ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(4)) dut (
    .CLK(CLK), .RST(RST), .bus(ia));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(0)) dut0 (
    .CLK(CLK), .RST(RST), .bus(ib));

  int total = 0;
  int bad   = 0;

  rsp_t  exp_a[$];
  rsp_t  exp_b[$];
  mreq_t exp_m[$];

  logic [31:0] mem [0:63];
  bit          pend = 0;
  logic [31:0] pend_d;
  bit          spur = 0;
  bit          auto_rsp = 1;

  logic [31:0] st_addr [6];
  logic [3:0]  st_be   [6];
  logic [31:0] st_wd   [6];

  logic        ib_rsp_v;
  logic [31:0] ib_rsp_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout or unexpected event, want none", nm);
  endtask

  task automatic push_a(input bit ls, input bit c, input logic [31:0] d);
    rsp_t e;
    e.ls = ls; e.chk = c; e.d = d;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input bit ls, input logic [31:0] d);
    rsp_t e;
    e.ls = ls; e.chk = 1'b1; e.d = d;
    exp_b.push_back(e);
  endtask

  task automatic push_m(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    mreq_t m;
    m.we = we; m.be = be; m.addr = a; m.wd = wd;
    exp_m.push_back(m);
  endtask

  // Memory model for dut: one-cycle response after each accept
  initial begin
    ia.mem_rsp_valid = 1'b0;
    ia.mem_rsp_data  = '0;
    forever begin
      @(posedge CLK); #1;
      ia.mem_rsp_valid = 1'b0;
      if (pend) begin
        ia.mem_rsp_valid = 1'b1;
        ia.mem_rsp_data  = pend_d;
        pend = 0;
      end else if (spur) begin
        ia.mem_rsp_valid = 1'b1;
        ia.mem_rsp_data  = 32'hDEADBEEF;
        spur = 0;
      end
    end
  end

  // Memory for dut0: echoes address xor a tag one cycle after accept
  always @(posedge CLK) begin
    ib_rsp_v <= ib.mem_req_valid & ib.mem_req_ready;
    ib_rsp_d <= ib.mem_req_addr ^ 32'h5A5A0000;
  end
  assign ib.mem_rsp_valid = ib_rsp_v;
  assign ib.mem_rsp_data  = ib_rsp_d;

  // Monitor / scoreboard
  initial begin
    rsp_t  e;
    mreq_t m;
    int    idx;
    forever begin
      @(negedge CLK);
      if (ia.if_rsp_valid || ia.ls_rsp_valid) begin
        chk("a_rsp_onehot", 32'(ia.if_rsp_valid & ia.ls_rsp_valid), 32'd0);
        if (exp_a.size() == 0) fail("a_rsp_unexpected");
        else begin
          e = exp_a.pop_front();
          chk("a_rsp_side_ls", 32'(ia.ls_rsp_valid), 32'(e.ls));
          if (e.chk) chk("a_rsp_data", e.ls ? ia.ls_rsp_data : ia.if_rsp_data, e.d);
        end
      end
      if (ib.if_rsp_valid || ib.ls_rsp_valid) begin
        chk("b_rsp_onehot", 32'(ib.if_rsp_valid & ib.ls_rsp_valid), 32'd0);
        if (exp_b.size() == 0) fail("b_rsp_unexpected");
        else begin
          e = exp_b.pop_front();
          chk("b_rsp_side_ls", 32'(ib.ls_rsp_valid), 32'(e.ls));
          chk("b_rsp_data", e.ls ? ib.ls_rsp_data : ib.if_rsp_data, e.d);
        end
      end
      if (ia.mem_req_valid && ia.mem_req_ready && !RST) begin
        if (exp_m.size() == 0) fail("m_unexpected");
        else begin
          m = exp_m.pop_front();
          chk("m_we",    32'(ia.mem_req_we), 32'(m.we));
          chk("m_be",    32'(ia.mem_req_be), 32'(m.be));
          chk("m_addr",  ia.mem_req_addr,  m.addr);
          chk("m_wdata", ia.mem_req_wdata, m.wd);
        end
        idx = int'(ia.mem_req_addr[7:2]);
        if (auto_rsp) begin
          pend   = 1;
          pend_d = mem[idx];
        end
        if (ia.mem_req_we) begin
          for (int b = 0; b < 4; b++)
            if (ia.mem_req_be[b]) mem[idx][8*b +: 8] = ia.mem_req_wdata[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_if_hs(output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while (!ia.if_req_ready && n < 40);
    if (!ia.if_req_ready) fail("if_hs_timeout");
    @(posedge CLK); #1;
    ia.if_req_valid = 1'b0;
  endtask

  task automatic wait_b;
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(ib.if_req_ready || ib.ls_req_ready) && n < 40);
    if (!(ib.if_req_ready || ib.ls_req_ready)) fail("b_hs_timeout");
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || exp_m.size() != 0 || pend) && n < 60) begin
      @(negedge CLK); n++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0 || exp_m.size() != 0) fail("drain_timeout");
    @(posedge CLK); #1;
  endtask

  task automatic set_store(input int i);
    ia.ls_req_we    = 1'b1;
    ia.ls_req_be    = st_be[i];
    ia.ls_req_addr  = st_addr[i];
    ia.ls_req_wdata = st_wd[i];
  endtask

  initial begin
    int n;
    int ls_i;
    bit hs_ls;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h0000_0013;
    st_addr[0] = 32'hC0; st_be[0] = 4'hF; st_wd[0] = 32'hAABBCCDD;
    st_addr[1] = 32'hC4; st_be[1] = 4'h1; st_wd[1] = 32'h00000011;
    st_addr[2] = 32'hC8; st_be[2] = 4'h2; st_wd[2] = 32'h00002200;
    st_addr[3] = 32'hCC; st_be[3] = 4'hC; st_wd[3] = 32'h33440000;
    st_addr[4] = 32'hD0; st_be[4] = 4'h6; st_wd[4] = 32'h00556600;
    st_addr[5] = 32'hD4; st_be[5] = 4'h8; st_wd[5] = 32'h77000000;

    RST = 1'b1;
    ia.if_req_valid = 1'b1; ia.if_req_addr = '0;
    ia.ls_req_valid = 1'b0; ia.ls_req_we = 1'b0; ia.ls_req_be = '0;
    ia.ls_req_addr = '0; ia.ls_req_wdata = '0; ia.mem_req_ready = 1'b1;
    ib.if_req_valid = 1'b0; ib.if_req_addr = '0;
    ib.ls_req_valid = 1'b0; ib.ls_req_we = 1'b0; ib.ls_req_be = '0;
    ib.ls_req_addr = '0; ib.ls_req_wdata = '0; ib.mem_req_ready = 1'b1;

    // 1: reset state, then a single fetch from 0x0
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_if_ready",  32'(ia.if_req_ready),  32'd0);
    chk("rst_mem_valid", 32'(ia.mem_req_valid), 32'd0);
    chk("rst_if_rsp",    32'(ia.if_rsp_valid),  32'd0);
    chk("rst_ls_rsp",    32'(ia.ls_rsp_valid),  32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    push_m(1'b0, 4'hF, 32'h0, 32'h0);
    push_a(1'b0, 1'b1, 32'h0000_0013);
    @(negedge CLK);
    chk("t1_if_ready_c0",  32'(ia.if_req_ready),  32'd1);
    chk("t1_mem_valid_c0", 32'(ia.mem_req_valid), 32'd0);
    @(posedge CLK); #1;
    ia.if_req_valid = 1'b0;
    @(negedge CLK);
    chk("t1_mem_valid_c1", 32'(ia.mem_req_valid), 32'd1);
    chk("t1_mem_addr_c1",  ia.mem_req_addr,       32'h0);
    @(negedge CLK);
    chk("t1_if_rsp_c2",    32'(ia.if_rsp_valid),  32'd0);
    @(negedge CLK);
    chk("t1_if_rsp_c3",    32'(ia.if_rsp_valid),  32'd1);
    chk("t1_if_data_c3",   ia.if_rsp_data,        32'h0000_0013);
    @(posedge CLK); #1;
    drain();

    // 2: contention, grants L L L L I L L
    for (int i = 0; i < 4; i++) push_m(1'b1, st_be[i], st_addr[i], st_wd[i]);
    push_m(1'b0, 4'hF, 32'h40, 32'h0);
    for (int i = 4; i < 6; i++) push_m(1'b1, st_be[i], st_addr[i], st_wd[i]);
    for (int i = 0; i < 4; i++) push_a(1'b1, 1'b0, '0);
    push_a(1'b0, 1'b1, 32'h1000_0010);
    for (int i = 0; i < 2; i++) push_a(1'b1, 1'b0, '0);
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h40;
    ls_i = 0; set_store(0); ia.ls_req_valid = 1'b1;
    n = 0;
    while (ls_i < 6 && n < 200) begin
      @(negedge CLK); n++;
      hs_ls = ia.ls_req_valid & ia.ls_req_ready;
      @(posedge CLK); #1;
      if (hs_ls) begin
        ls_i++;
        if (ls_i < 6) set_store(ls_i);
      end
    end
    ia.ls_req_valid = 1'b0; ia.if_req_valid = 1'b0; ia.ls_req_we = 1'b0;
    if (ls_i < 6) fail("t2_timeout");
    drain();

    // 3: memory stalls five cycles in ISSUE
    ia.mem_req_ready = 1'b0;
    push_m(1'b0, 4'hF, 32'h20, 32'h0);
    push_a(1'b1, 1'b1, 32'h1000_0008);
    ia.ls_req_valid = 1'b1; ia.ls_req_we = 1'b0; ia.ls_req_be = 4'hF;
    ia.ls_req_addr = 32'h20; ia.ls_req_wdata = '0;
    @(negedge CLK);
    chk("t3_ls_ready", 32'(ia.ls_req_ready), 32'd1);
    @(posedge CLK); #1;
    ia.ls_req_we = 1'b1; ia.ls_req_addr = 32'hFC; ia.ls_req_wdata = 32'hFFFF_FFFF; ia.ls_req_be = 4'h3;
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h44;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("t3_mem_valid", 32'(ia.mem_req_valid), 32'd1);
      chk("t3_mem_addr",  ia.mem_req_addr,       32'h20);
      chk("t3_mem_we",    32'(ia.mem_req_we),    32'd0);
      chk("t3_mem_be",    32'(ia.mem_req_be),    32'hF);
      chk("t3_mem_wdata", ia.mem_req_wdata,      32'h0);
      chk("t3_if_ready",  32'(ia.if_req_ready),  32'd0);
      chk("t3_ls_ready",  32'(ia.ls_req_ready),  32'd0);
      @(posedge CLK); #1;
    end
    ia.ls_req_valid = 1'b0; ia.ls_req_we = 1'b0;
    ia.mem_req_ready = 1'b1;
    push_m(1'b0, 4'hF, 32'h44, 32'h0);
    push_a(1'b0, 1'b1, 32'h1000_0011);
    wait_if_hs(n);
    drain();

    // 4: spurious memory response while idle
    @(negedge CLK);
    spur = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t4_if_rsp",    32'(ia.if_rsp_valid),  32'd0);
      chk("t4_ls_rsp",    32'(ia.ls_rsp_valid),  32'd0);
      chk("t4_mem_valid", 32'(ia.mem_req_valid), 32'd0);
    end
    @(posedge CLK); #1;
    push_m(1'b0, 4'hF, 32'h48, 32'h0);
    push_a(1'b0, 1'b1, 32'h1000_0012);
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h48;
    wait_if_hs(n);
    chk("t4_idle_ready_immediate", 32'(n), 32'd1);
    drain();

    // 5: reset while waiting for the memory response
    auto_rsp = 0;
    push_m(1'b0, 4'hF, 32'h80, 32'h0);
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h80;
    wait_if_hs(n);
    @(posedge CLK); #1;
    RST = 1'b1;
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h88;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("t5_if_ready",  32'(ia.if_req_ready),  32'd0);
    chk("t5_mem_valid", 32'(ia.mem_req_valid), 32'd0);
    chk("t5_mem_addr",  ia.mem_req_addr,       32'h0);
    chk("t5_mem_be",    32'(ia.mem_req_be),    32'h0);
    chk("t5_if_data",   ia.if_rsp_data,        32'h0);
    chk("t5_ls_data",   ia.ls_rsp_data,        32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    ia.if_req_valid = 1'b0;
    @(negedge CLK);
    spur = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t5_late_if_rsp", 32'(ia.if_rsp_valid), 32'd0);
      chk("t5_late_ls_rsp", 32'(ia.ls_rsp_valid), 32'd0);
    end
    @(posedge CLK); #1;
    auto_rsp = 1;
    push_m(1'b0, 4'hF, 32'h84, 32'h0);
    push_a(1'b0, 1'b1, 32'h1000_0021);
    ia.if_req_valid = 1'b1; ia.if_req_addr = 32'h84;
    wait_if_hs(n);
    drain();

    // 6: MAX_LSU_STREAK=0, fetch always wins while valid
    ib.if_req_valid = 1'b1; ib.if_req_addr = 32'h10;
    ib.ls_req_valid = 1'b1; ib.ls_req_we = 1'b0; ib.ls_req_be = 4'hF;
    ib.ls_req_addr = 32'h200; ib.ls_req_wdata = '0;
    push_b(1'b0, 32'h5A5A_0010);
    @(negedge CLK);
    chk("t6_if_ready1", 32'(ib.if_req_ready), 32'd1);
    chk("t6_ls_ready1", 32'(ib.ls_req_ready), 32'd0);
    @(posedge CLK); #1;
    ib.if_req_addr = 32'h14;
    push_b(1'b0, 32'h5A5A_0014);
    wait_b();
    chk("t6_if_ready2", 32'(ib.if_req_ready), 32'd1);
    chk("t6_ls_ready2", 32'(ib.ls_req_ready), 32'd0);
    @(posedge CLK); #1;
    ib.if_req_valid = 1'b0;
    push_b(1'b1, 32'h5A5A_0200);
    wait_b();
    chk("t6_ls_ready3", 32'(ib.ls_req_ready), 32'd1);
    @(posedge CLK); #1;
    ib.ls_req_valid = 1'b0;
    drain();

    chk("end_exp_a_empty", 32'(exp_a.size()), 32'd0);
    chk("end_exp_b_empty", 32'(exp_b.size()), 32'd0);
    chk("end_exp_m_empty", 32'(exp_m.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
